stream_max_min_8: RTL and testbench
===================================

Name: stream_max_min_8

Overview:
- Downstream consumer of the 8-bit cascade magnitude comparator.
- Accepts a window of COUNT unsigned 8-bit samples on a valid strobe and tracks the running maximum and minimum, with the index of each.
- Raises done when the window completes.
- Used after sample capture to feed range and threshold logic.

Parameters:
- COUNT, 8, samples per window; legal range 2..256.
- CW, $clog2(COUNT), local width of the index and counter; derived, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a new window; single-cycle pulse.
- valid_in  input  1  data_in is valid this cycle.
- data_in  input  8  unsigned sample.
- ready  output  1  high when a sample is accepted; equals (state==TRACK).
- busy  output  1  window in progress.
- done  output  1  window complete, results stable; level signal.
- max_out  output  8  largest sample in the window.
- min_out  output  8  smallest sample in the window.
- max_idx  output  CW  index of the first occurrence of max_out.
- min_idx  output  CW  index of the first occurrence of min_out.
- count  output  CW  samples accepted so far in the current window.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, max_out=8'h00, min_out=8'hFF, max_idx=0, min_idx=0, count=0, busy=0, done=0, ready=0.
- Reset mid-window: all state is discarded. Reset has priority over start and valid_in.
- FSM states: IDLE, TRACK, DONE.
- IDLE:
  - start -> TRACK; count=0, busy=1, done=0.
  - valid_in is ignored.
- TRACK:
  - A sample is accepted when valid_in=1. Accepted sample index = count.
  - First sample (count==0): loads max_out, min_out, and both idx to 0.
  - Later samples:
    - data_in > max_out: max_out and max_idx update.
    - data_in < min_out: min_out and min_idx update.
    - Equal values never update, so ties keep the first occurrence.
    - A single sample can update both only when it is the first sample.
  - count increments on each accepted sample.
  - Accepting the sample at count==COUNT-1 -> DONE; count wraps to 0, busy=0, done=1.
  - start in TRACK aborts and restarts: count=0, outputs held until the new first sample. start has priority over valid_in; a coincident sample is dropped.
  - Gaps in valid_in are allowed; there is no timeout.
- DONE:
  - done stays high and outputs are held.
  - valid_in is ignored.
  - start -> TRACK as from IDLE; done drops the next cycle.
- Latency: each register updates on the edge that accepts the sample, so results are visible the following cycle. done is asserted the cycle after the last sample is accepted, together with the final max/min.
- Comparison:
  - Two instances of the 8-bit comparator: (data_in vs max_out) and (data_in vs min_out).
  - Cascade inputs are tied to l=0, g=0, e=1.
  - All 8 bits [7:0] must take part in the comparison. The bench includes cases that differ only in bits [7:4].
- Arithmetic: unsigned only. count never exceeds COUNT-1.

Decomposition:
- Shared package/header:
  - FSM state encoding (IDLE=2'd0, TRACK=2'd1, DONE=2'd2).
  - Cascade tie-off constants CMP_L0=0, CMP_G0=0, CMP_E0=1.
- Sub-module: one natural sub-module, the 8-bit cascade comparator, instantiated twice.
- The FSM, registers and index tracking live in stream_max_min_8.

Test Plan:
- Basic window:
  - Stimulus: start, then back-to-back 5,200,3,200,3,77,128,0.
  - Response: done one cycle after the 8th sample; max_out=200, max_idx=1, min_out=0, min_idx=7.
- Bits [7:4] only:
  - Stimulus: start, then 8'h0F, 8'hF0, 8'h10, 8'h01, remaining samples 8'h08.
  - Response: max_out=8'hF0 idx1, min_out=8'h01 idx3.
- All equal:
  - Stimulus: 8 samples of 8'h42 with valid_in toggling 1,0,1,0.
  - Response: max=min=8'h42, both idx=0, done after the 8th accepted sample; count increments only on valid cycles.
- Start mid-window:
  - Stimulus: 3 samples (9,9,9), then start with valid_in=1 and data 8'hFF, then 8 samples 1..8.
  - Response: 8'hFF dropped; max=8 idx7, min=1 idx0.
- Reset mid-window:
  - Stimulus: rst after 4 samples.
  - Response: next cycle state IDLE, busy=0, max_out=0, min_out=8'hFF; valid_in ignored until start.
- Restart from DONE:
  - Stimulus: start in DONE.
  - Response: done=0 next cycle, ready=1; samples 8'hFF,8'h00 alternating give max=FF idx0, min=00 idx1.

Source files
------------

// File: rtl/stream_max_min_8_pkg.sv
// Shared types and constants for the streaming max/min tracker.
package stream_max_min_8_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Cascade inputs for a stand-alone comparator: "equal so far"
  localparam logic CMP_L0 = 1'b0;
  localparam logic CMP_G0 = 1'b0;
  localparam logic CMP_E0 = 1'b1;

endpackage

// File: rtl/stream_max_min_8_cmp.sv
// 8-bit cascadable magnitude comparator; the most significant differing bit decides,
// and fully equal operands pass the cascade inputs through.
module stream_max_min_8_cmp
  import stream_max_min_8_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_l,
  input  logic              i_g,
  input  logic              i_e,
  output logic              o_lt_c,
  output logic              o_gt_c,
  output logic              o_eq_c
);

  // Scan LSB to MSB so a higher differing bit overrides any lower one
  always_comb begin
    o_lt_c = i_l;
    o_gt_c = i_g;
    o_eq_c = i_e;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i_a[i] != i_b[i]) begin
        o_gt_c = i_a[i];
        o_lt_c = i_b[i];
        o_eq_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stream_max_min_8.sv
// Tracks the running maximum and minimum (with first-occurrence index) over a
// window of COUNT unsigned 8-bit samples, raising done when the window completes.
module stream_max_min_8
  import stream_max_min_8_pkg::*;
#(
  parameter  int unsigned COUNT = 8,
  localparam int unsigned CW    = $clog2(COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] min_out,
  output logic [CW-1:0]     max_idx,
  output logic [CW-1:0]     min_idx,
  output logic [CW-1:0]     count
);

  state_t            r_state;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] r_min;
  logic [CW-1:0]     r_max_idx;
  logic [CW-1:0]     r_min_idx;
  logic [CW-1:0]     r_count;

  state_t            w_state_nxt;
  logic [DATA_W-1:0] w_max_nxt;
  logic [DATA_W-1:0] w_min_nxt;
  logic [CW-1:0]     w_max_idx_nxt;
  logic [CW-1:0]     w_min_idx_nxt;
  logic [CW-1:0]     w_count_nxt;

  logic w_max_lt, w_max_gt, w_max_eq;
  logic w_min_lt, w_min_gt, w_min_eq;
  logic w_max_upd;
  logic w_min_upd;

  stream_max_min_8_cmp u_cmp_max (
    .i_a    (data_in),
    .i_b    (r_max),
    .i_l    (CMP_L0),
    .i_g    (CMP_G0),
    .i_e    (CMP_E0),
    .o_lt_c (w_max_lt),
    .o_gt_c (w_max_gt),
    .o_eq_c (w_max_eq)
  );

  stream_max_min_8_cmp u_cmp_min (
    .i_a    (data_in),
    .i_b    (r_min),
    .i_l    (CMP_L0),
    .i_g    (CMP_G0),
    .i_e    (CMP_E0),
    .o_lt_c (w_min_lt),
    .o_gt_c (w_min_gt),
    .o_eq_c (w_min_eq)
  );

  // Strict inequality only: ties keep the first occurrence
  assign w_max_upd = w_max_gt & ~w_max_lt & ~w_max_eq;
  assign w_min_upd = w_min_lt & ~w_min_gt & ~w_min_eq;

  // State register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_max     <= 8'h00;
      r_min     <= 8'hFF;
      r_max_idx <= '0;
      r_min_idx <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_max     <= w_max_nxt;
      r_min     <= w_min_nxt;
      r_max_idx <= w_max_idx_nxt;
      r_min_idx <= w_min_idx_nxt;
      r_count   <= w_count_nxt;
    end
  end

  // Next-state and sample tracking; start outranks valid_in in every state
  always_comb begin
    w_state_nxt   = r_state;
    w_max_nxt     = r_max;
    w_min_nxt     = r_min;
    w_max_idx_nxt = r_max_idx;
    w_min_idx_nxt = r_min_idx;
    w_count_nxt   = r_count;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = TRACK;
          w_count_nxt = '0;
        end
      end
      TRACK: begin
        if (start) begin
          w_count_nxt = '0;
        end else if (valid_in) begin
          if (r_count == '0) begin
            w_max_nxt     = data_in;
            w_min_nxt     = data_in;
            w_max_idx_nxt = '0;
            w_min_idx_nxt = '0;
          end else begin
            if (w_max_upd) begin
              w_max_nxt     = data_in;
              w_max_idx_nxt = r_count;
            end
            if (w_min_upd) begin
              w_min_nxt     = data_in;
              w_min_idx_nxt = r_count;
            end
          end
          if (r_count == CW'(COUNT - 1)) begin
            w_count_nxt = '0;
            w_state_nxt = DONE;
          end else begin
            w_count_nxt = r_count + CW'(1);
          end
        end
      end
      DONE: begin
        if (start) begin
          w_state_nxt = TRACK;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign ready   = (r_state == TRACK);
  assign busy    = (r_state == TRACK);
  assign done    = (r_state == DONE);
  assign max_out = r_max;
  assign min_out = r_min;
  assign max_idx = r_max_idx;
  assign min_idx = r_min_idx;
  assign count   = r_count;

endmodule

// File: tb/tb_stream_max_min_8.sv
// Directed bench for stream_max_min_8 with hand-computed expectations.
module tb_stream_max_min_8;

  localparam int unsigned CW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic          valid_in;
  logic [7:0]    data_in;
  logic          ready;
  logic          busy;
  logic          done;
  logic [7:0]    max_out;
  logic [7:0]    min_out;
  logic [CW-1:0] max_idx;
  logic [CW-1:0] min_idx;
  logic [CW-1:0] count;

  int n_checks;
  int n_errors;

  stream_max_min_8 #(.COUNT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .valid_in (valid_in),
    .data_in  (data_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .max_out  (max_out),
    .min_out  (min_out),
    .max_idx  (max_idx),
    .min_idx  (min_idx),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read there too
  task automatic step(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    start    = s;
    valid_in = v;
    data_in  = d;
  endtask

  task automatic chk_result(input string tag, input logic [7:0] mx, input logic [CW-1:0] mxi,
                            input logic [7:0] mn, input logic [CW-1:0] mni);
    chk({tag, ".done"},    32'(done),    32'd1);
    chk({tag, ".busy"},    32'(busy),    32'd0);
    chk({tag, ".max"},     32'(max_out), 32'(mx));
    chk({tag, ".max_idx"}, 32'(max_idx), 32'(mxi));
    chk({tag, ".min"},     32'(min_out), 32'(mn));
    chk({tag, ".min_idx"}, 32'(min_idx), 32'(mni));
    chk({tag, ".count"},   32'(count),   32'd0);
  endtask

  logic [7:0] basic [8];
  logic [7:0] nib   [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    basic = '{8'd5, 8'd200, 8'd3, 8'd200, 8'd3, 8'd77, 8'd128, 8'd0};
    nib   = '{8'h0F, 8'hF0, 8'h10, 8'h01, 8'h08, 8'h08, 8'h08, 8'h08};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.ready",   32'(ready),   32'd0);
    chk("rst.busy",    32'(busy),    32'd0);
    chk("rst.done",    32'(done),    32'd0);
    chk("rst.max",     32'(max_out), 32'h00);
    chk("rst.min",     32'(min_out), 32'hFF);
    chk("rst.max_idx", 32'(max_idx), 32'd0);
    chk("rst.min_idx", 32'(min_idx), 32'd0);
    chk("rst.count",   32'(count),   32'd0);
    rst = 1'b0;

    // Valid samples in IDLE are ignored
    step(1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b0, 8'h00);
    chk("idle.count", 32'(count),   32'd0);
    chk("idle.max",   32'(max_out), 32'h00);

    // Basic window
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, basic[i]);
      if (i == 0) begin
        chk("basic.ready0", 32'(ready), 32'd1);
        chk("basic.busy0",  32'(busy),  32'd1);
        chk("basic.count0", 32'(count), 32'd0);
      end
      if (i == 7) begin
        chk("basic.count7", 32'(count), 32'd7);
        chk("basic.done7",  32'(done),  32'd0);
      end
    end
    step(1'b0, 1'b0, 8'h00);
    chk_result("basic", 8'd200, 3'd1, 8'd0, 3'd7);
    chk("basic.ready", 32'(ready), 32'd0);

    // DONE holds results and ignores samples
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    chk_result("hold", 8'd200, 3'd1, 8'd0, 3'd7);

    // Samples differing only in the upper nibble
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, nib[i]);
    step(1'b0, 1'b0, 8'h00);
    chk_result("nib", 8'hF0, 3'd1, 8'h01, 3'd3);

    // All equal with valid_in gaps; junk data on invalid cycles
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, (i % 2) == 0, ((i % 2) == 0) ? 8'h42 : 8'h00);
      if (i == 6) chk("eq.count3", 32'(count), 32'd3);
      if (i == 14) chk("eq.done_early", 32'(done), 32'd0);
    end
    step(1'b0, 1'b0, 8'h00);
    chk_result("eq", 8'h42, 3'd0, 8'h42, 3'd0);

    // Restart mid-window; coincident sample dropped
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'd9);
    step(1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'd1);
    chk("abort.count", 32'(count),   32'd0);
    chk("abort.busy",  32'(busy),    32'd1);
    chk("abort.held",  32'(max_out), 32'd9);
    for (int i = 2; i <= 8; i++) step(1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b0, 8'h00);
    chk_result("abort", 8'd8, 3'd7, 8'd1, 3'd0);

    // Restart from DONE with alternating extremes
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    chk("redo.done",  32'(done),  32'd0);
    chk("redo.ready", 32'(ready), 32'd1);
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, ((i % 2) == 0) ? 8'hFF : 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk_result("redo", 8'hFF, 3'd0, 8'h00, 3'd1);

    // Reset mid-window
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'd10);
    step(1'b0, 1'b1, 8'd20);
    step(1'b0, 1'b1, 8'd30);
    step(1'b0, 1'b1, 8'd40);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; valid_in = 1'b1; data_in = 8'd55;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.busy",  32'(busy),    32'd0);
    chk("mrst.ready", 32'(ready),   32'd0);
    chk("mrst.max",   32'(max_out), 32'h00);
    chk("mrst.min",   32'(min_out), 32'hFF);
    chk("mrst.count", 32'(count),   32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b0, 8'h00);
    chk("mrst.ign_count", 32'(count),   32'd0);
    chk("mrst.ign_busy",  32'(busy),    32'd0);
    chk("mrst.ign_max",   32'(max_out), 32'h00);
    chk("mrst.ign_min",   32'(min_out), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
